// File: rtl/tape_rx_zxdos.sv
// ZX80/ZX81 cassette receiver: glitch-filters the tape level, counts pulses per bit,
// assembles bytes MSB first and queues them in a small FIFO with valid/ready output.
// Optional macro TAPE_RX_NAME_STRIP_EN drops each block's leading filename bytes.

module tape_rx_zxdos #(
    parameter int FILT        = 4,
    parameter int MIN_HIGH    = 20,
    parameter int GAP_CYCLES  = 250,
    parameter int ZERO_MIN    = 2,
    parameter int ZERO_MAX    = 6,
    parameter int ONE_MIN     = 7,
    parameter int ONE_MAX     = 12,
    parameter int IDLE_CYCLES = 250000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk500,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        tape_in,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [15:0] rx_count,
    output logic        rec_on,
    output logic        bit_err,
    output logic        overrun,
    output logic        block_end
);

    localparam int FW = $clog2(FILT + 1);
    localparam int HW = $clog2(MIN_HIGH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
    localparam logic [HW-1:0] HI_MIN    = HW'(MIN_HIGH);
    localparam logic [17:0]   GAP_END   = 18'(GAP_CYCLES);
    localparam logic [17:0]   IDLE_END  = 18'(IDLE_CYCLES);
    localparam logic [3:0]    Z_MIN     = 4'(ZERO_MIN);
    localparam logic [3:0]    Z_MAX     = 4'(ZERO_MAX);
    localparam logic [3:0]    O_MIN     = 4'(ONE_MIN);
    localparam logic [3:0]    O_MAX     = 4'(ONE_MAX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic          sync1, sync2, lvl, lvl_q;
    logic [FW-1:0] flt_cnt;
    logic          lvl_rise, lvl_fall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk500 or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            lvl     <= 1'b0;
            lvl_q   <= 1'b0;
            flt_cnt <= '0;
        end else begin
            sync1 <= tape_in;
            sync2 <= sync1;
            lvl_q <= lvl;
            if (sync2 == lvl) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FILT_LAST) begin
                lvl     <= sync2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign lvl_rise = lvl & ~lvl_q;
    assign lvl_fall = ~lvl & lvl_q;

    logic [1:0]    state;
    logic [3:0]    pulse_cnt;
    logic [HW-1:0] hi_cnt;
    logic [17:0]   low_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          push_req;
    logic [7:0]    push_byte;
    logic          cnt_clr;
`ifdef TAPE_RX_NAME_STRIP_EN
    logic          name_done;
`endif

    logic       is_zero, is_one, bit_ok;
    logic [7:0] shift_next;

    assign is_zero    = (pulse_cnt >= Z_MIN) && (pulse_cnt <= Z_MAX);
    assign is_one     = (pulse_cnt >= O_MIN) && (pulse_cnt <= O_MAX);
    assign bit_ok     = is_zero | is_one;
    assign shift_next = {shift[6:0], is_one};

    always_ff @(posedge clk500 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pulse_cnt <= '0;
            hi_cnt    <= '0;
            low_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rec_on    <= 1'b0;
            bit_err   <= 1'b0;
            block_end <= 1'b0;
            push_req  <= 1'b0;
            push_byte <= '0;
            cnt_clr   <= 1'b0;
`ifdef TAPE_RX_NAME_STRIP_EN
            name_done <= 1'b0;
`endif
        end else begin
            bit_err   <= 1'b0;
            block_end <= 1'b0;
            push_req  <= 1'b0;
            cnt_clr   <= 1'b0;
            if (!enable) begin
                // Disarming mid-block aborts it; the FIFO is left untouched.
                if (state != S_IDLE) begin
                    block_end <= 1'b1;
                    rec_on    <= 1'b0;
                    bit_cnt   <= '0;
                    shift     <= '0;
                    state     <= S_IDLE;
`ifdef TAPE_RX_NAME_STRIP_EN
                    name_done <= 1'b0;
`endif
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (lvl_rise) begin
                            pulse_cnt <= 4'd1;
                            hi_cnt    <= '0;
                            rec_on    <= 1'b1;
                            cnt_clr   <= 1'b1;
                            state     <= S_HIGH;
                        end
                    end
                    S_HIGH: begin
                        if (lvl_fall) begin
                            low_cnt <= '0;
                            if (hi_cnt < HI_MIN) begin
                                bit_err   <= 1'b1;
                                pulse_cnt <= '0;
                                state     <= S_GAP;
                            end else begin
                                state <= S_LOW;
                            end
                        end else if (hi_cnt < HI_MIN) begin
                            hi_cnt <= hi_cnt + 1'b1;
                        end
                    end
                    S_LOW: begin
                        if (lvl_rise) begin
                            if (pulse_cnt != 4'hF) pulse_cnt <= pulse_cnt + 4'd1;
                            hi_cnt <= '0;
                            state  <= S_HIGH;
                        end else if (low_cnt == GAP_END) begin
                            if (bit_ok) begin
                                shift   <= shift_next;
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
`ifdef TAPE_RX_NAME_STRIP_EN
                                    // Filename bytes are swallowed up to and including the bit7 terminator.
                                    if (!name_done) begin
                                        name_done <= shift_next[7];
                                    end else begin
                                        push_req  <= 1'b1;
                                        push_byte <= shift_next;
                                    end
`else
                                    push_req  <= 1'b1;
                                    push_byte <= shift_next;
`endif
                                end
                            end else begin
                                bit_err <= 1'b1;
                            end
                            low_cnt <= low_cnt + 18'd1;
                            state   <= S_GAP;
                        end else begin
                            low_cnt <= low_cnt + 18'd1;
                        end
                    end
                    S_GAP: begin
                        if (lvl_rise) begin
                            pulse_cnt <= 4'd1;
                            hi_cnt    <= '0;
                            state     <= S_HIGH;
                        end else if (low_cnt >= IDLE_END) begin
                            block_end <= 1'b1;
                            rec_on    <= 1'b0;
                            bit_cnt   <= '0;
                            shift     <= '0;
                            state     <= S_IDLE;
`ifdef TAPE_RX_NAME_STRIP_EN
                            name_done <= 1'b0;
`endif
                        end else begin
                            low_cnt <= low_cnt + 18'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, pop, push_ok;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_valid = (wr_ptr != rd_ptr);
    assign rx_data  = mem[rd_ptr[AW-1:0]];
    assign pop      = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign push_ok  = push_req & (~full | pop);

    always_ff @(posedge clk500 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            overrun  <= 1'b0;
            // NOTE: the storage is reset too so rx_data reads 0 out of reset; fine for a few flops.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overrun <= push_req & ~push_ok;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_byte;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (cnt_clr) begin
                rx_count <= '0;
            end else if (push_ok && rx_count != 16'hFFFF) begin
                rx_count <= rx_count + 16'd1;
            end
        end
    end

endmodule
